// File: rtl/stage4_compress.sv
// stage4_compress
//   Rice-encodes one frame of signed 16-bit residuals per frame period. Residuals
//   of the open frame are buffered in a ring FIFO while their statistics are
//   gathered; at the frame boundary the Rice parameter k is estimated and the
//   closed frame is encoded (header + one code per cycle) while the next frame
//   fills. Codes are packed MSB-first into 16-bit words written on two RAM ports.
// Ports
//   iClock, iReset(async, active-low), iEnable (0 = freeze everything)
//   iFrameDone  frame boundary pulse; iM warm-up count of the new frame
//   iValid/iResidual  residual input stream
//   oRamEnable1/oRamAddress1/oRamData1  first (lower address) word written this cycle
//   oRamEnable2/oRamAddress2/oRamData2  second word in the same cycle (addr+1)
//   oFrameDone  one-cycle pulse after a frame's last word is written
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a boundary pulse that closes a real frame
// S_KEST   | compute k from the closed frame's statistics
// S_HDR    | append the 10-bit residual header
// S_DATA   | append one Rice code per cycle, rem_q counts down
// S_FLUSH  | write a zero-padded partial word, if any
// S_FDONE  | raise oFrameDone after the flushed word
module stage4_compress #(
  parameter int FRAME_MAX = 4096,
  parameter int ADDR_W    = 16,
  parameter int KMAX      = 14
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iFrameDone,
  input  logic [3:0]        iM,
  input  logic              iValid,
  input  logic [15:0]       iResidual,
  output logic              oRamEnable1,
  output logic [ADDR_W-1:0] oRamAddress1,
  output logic [15:0]       oRamData1,
  output logic              oRamEnable2,
  output logic [ADDR_W-1:0] oRamAddress2,
  output logic [15:0]       oRamData2,
  output logic              oFrameDone
);

  // A few slack entries: the new frame starts pushing before the closed
  // frame's first residual is popped, so a full frame must not block it.
  localparam int DEPTH = FRAME_MAX + 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int N_W   = $clog2(FRAME_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEST  = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_FDONE = 3'd5;

  function automatic logic [16:0] zigzag(input logic [15:0] r);
    return {r, 1'b0} ^ {17{r[15]}};
  endfunction

  logic [15:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [N_W-1:0]    n_q, n_d, n_cls_q, n_cls_d, rem_q, rem_d;
  logic [28:0]       s_q, s_d, s_cls_q, s_cls_d;
  logic [16:0]       umax_q, umax_d, umax_cls_q, umax_cls_d;
  logic [3:0]        m_q, m_d, k_q, k_d, cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic [2:0]        state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr1_q, addr1_d, addr2_q, addr2_d;
  logic [15:0]       data1_q, data1_d, data2_q, data2_d;
  logic              en1_q, en1_d, en2_q, en2_d, fdone_q, fdone_d;

  // iM only describes the expected frame length; the observed count wins.
  logic unused_m;
  assign unused_m = ^m_q;

  logic        close, push;
  logic [16:0] u_in, u_rd, q_rd;
  logic [4:0]  k_sum, u_bits, k_est;
  logic [31:0] code_val, app_val;
  logic [5:0]  code_len, app_len;
  logic        app_en;
  logic [6:0]  total, sh;
  logic [1:0]  n_words;
  logic [63:0] wide, wide_sh;

  assign close = iEnable & iFrameDone;
  // A sample arriving with the boundary pulse is the first of the new frame.
  assign push  = iEnable & iValid & (close | (n_q < N_W'(FRAME_MAX)));
  assign u_in  = zigzag(iResidual);

  always_ff @(posedge iClock) begin
    if (push) fifo_mem[wr_ptr_q] <= iResidual;
  end

  // Rice parameter estimate from the closed frame's statistics.
  always_comb begin
    k_sum = 5'(KMAX);
    for (int i = KMAX; i >= 0; i--) begin
      if ((29'(n_cls_q) << i) >= s_cls_q) k_sum = 5'(i);
    end
    u_bits = '0;
    for (int i = 0; i < 17; i++) begin
      if (umax_cls_q[i]) u_bits = 5'(i + 1);
    end
    k_est = k_sum;
    // Raising k to bitlen(Umax)-4 keeps every quotient below 16.
    if (u_bits > 5'd4 && (u_bits - 5'd4) > k_est) k_est = u_bits - 5'd4;
    if (k_est > 5'(KMAX)) k_est = 5'(KMAX);
  end

  always_comb begin
    u_rd     = zigzag(fifo_mem[rd_ptr_q]);
    q_rd     = u_rd >> k_q;
    code_val = (32'd1 << k_q) | (32'(u_rd) & ((32'd1 << k_q) - 32'd1));
    code_len = 6'(q_rd) + 6'd1 + 6'(k_q);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;   rd_ptr_d = rd_ptr_q;
    n_d = n_q;             s_d = s_q;             umax_d = umax_q;
    n_cls_d = n_cls_q;     s_cls_d = s_cls_q;     umax_cls_d = umax_cls_q;
    m_d = m_q;             prev_d = prev_q;       state_d = state_q;
    k_d = k_q;             rem_d = rem_q;         acc_d = acc_q;
    cnt_d = cnt_q;         addr_d = addr_q;
    addr1_d = addr1_q;     data1_d = data1_q;
    addr2_d = addr2_q;     data2_d = data2_q;
    en1_d = 1'b0;          en2_d = 1'b0;          fdone_d = 1'b0;
    app_en = 1'b0;         app_val = '0;          app_len = '0;
    total = 7'(cnt_q);     sh = '0;               n_words = '0;
    wide = '0;             wide_sh = '0;

    if (iEnable) begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

      if (close) begin
        n_cls_d    = n_q;
        s_cls_d    = s_q;
        umax_cls_d = umax_q;
        m_d        = iM;
        prev_d     = 1'b1;
        n_d        = push ? N_W'(1) : '0;
        s_d        = push ? 29'(u_in) : '0;
        umax_d     = push ? u_in : '0;
      end else if (push) begin
        n_d = n_q + N_W'(1);
        s_d = s_q + 29'(u_in);
        if (u_in > umax_q) umax_d = u_in;
      end

      case (state_q)
        S_IDLE:  if (close && prev_q) state_d = S_KEST;
        S_KEST: begin
          k_d     = k_est[3:0];
          rem_d   = n_cls_q;
          state_d = S_HDR;
        end
        S_HDR: begin
          app_en  = 1'b1;
          app_val = 32'(k_q);        // 00 method, 0000 partition order, k
          app_len = 6'd10;
          state_d = (rem_q == '0) ? S_FLUSH : S_DATA;
        end
        S_DATA: begin
          app_en   = 1'b1;
          app_val  = code_val;
          app_len  = code_len;
          rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
          rem_d    = rem_q - N_W'(1);
          if (rem_q == N_W'(1)) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          if (cnt_q != '0) begin
            en1_d   = 1'b1;
            addr1_d = addr_q;
            data1_d = acc_q;
            addr_d  = addr_q + ADDR_W'(1);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_FDONE;
          end else begin
            fdone_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_FDONE: begin
          fdone_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // Pending bits sit left-aligned in acc_q; a code of up to 30 bits is
      // placed right behind them, so at most two words complete per cycle.
      if (app_en) begin
        total   = 7'(cnt_q) + 7'(app_len);
        sh      = 7'd64 - total;
        wide    = {acc_q, 48'd0} | ({32'd0, app_val} << sh);
        n_words = (total >= 7'd32) ? 2'd2 : (total >= 7'd16) ? 2'd1 : 2'd0;
        wide_sh = wide << {n_words, 4'b0000};
        acc_d   = wide_sh[63:48];
        cnt_d   = 4'(total - {1'b0, n_words, 4'b0000});
        addr_d  = addr_q + ADDR_W'(n_words);
        if (n_words != 2'd0) begin
          en1_d   = 1'b1;
          addr1_d = addr_q;
          data1_d = wide[63:48];
        end
        if (n_words == 2'd2) begin
          en2_d   = 1'b1;
          addr2_d = addr_q + ADDR_W'(1);
          data2_d = wide[47:32];
        end
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wr_ptr_q <= '0;  rd_ptr_q <= '0;
      n_q <= '0;       s_q <= '0;       umax_q <= '0;
      n_cls_q <= '0;   s_cls_q <= '0;   umax_cls_q <= '0;
      m_q <= '0;       prev_q <= 1'b0;  state_q <= S_IDLE;
      k_q <= '0;       rem_q <= '0;     acc_q <= '0;
      cnt_q <= '0;     addr_q <= '0;
      en1_q <= 1'b0;   addr1_q <= '0;   data1_q <= '0;
      en2_q <= 1'b0;   addr2_q <= '0;   data2_q <= '0;
      fdone_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
      n_q <= n_d;            s_q <= s_d;            umax_q <= umax_d;
      n_cls_q <= n_cls_d;    s_cls_q <= s_cls_d;    umax_cls_q <= umax_cls_d;
      m_q <= m_d;            prev_q <= prev_d;      state_q <= state_d;
      k_q <= k_d;            rem_q <= rem_d;        acc_q <= acc_d;
      cnt_q <= cnt_d;        addr_q <= addr_d;
      en1_q <= en1_d;        addr1_q <= addr1_d;    data1_q <= data1_d;
      en2_q <= en2_d;        addr2_q <= addr2_d;    data2_q <= data2_d;
      fdone_q <= fdone_d;
    end
  end

  assign oRamEnable1  = en1_q;
  assign oRamAddress1 = addr1_q;
  assign oRamData1    = data1_q;
  assign oRamEnable2  = en2_q;
  assign oRamAddress2 = addr2_q;
  assign oRamData2    = data2_q;
  assign oFrameDone   = fdone_q;

endmodule

// File: tb/tb_stage4_compress.sv
module tb_stage4_compress;
  logic        iClock = 1'b0;
  logic        iReset, iEnable, iFrameDone, iValid;
  logic [3:0]  iM;
  logic [15:0] iResidual;
  logic        oRamEnable1, oRamEnable2, oFrameDone;
  logic [15:0] oRamAddress1, oRamAddress2, oRamData1, oRamData2;

  stage4_compress dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iFrameDone(iFrameDone),
    .iM(iM), .iValid(iValid), .iResidual(iResidual),
    .oRamEnable1(oRamEnable1), .oRamAddress1(oRamAddress1), .oRamData1(oRamData1),
    .oRamEnable2(oRamEnable2), .oRamAddress2(oRamAddress2), .oRamData2(oRamData2),
    .oFrameDone(oFrameDone)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write capture, in port order (port 1 is the lower address).
  logic [15:0] cap_addr[$];
  logic [15:0] cap_data[$];
  int fd_cnt = 0;
  int done_idx[8];
  int p2_alone = 0;

  always @(negedge iClock) begin
    if (oRamEnable1) begin
      cap_addr.push_back(oRamAddress1);
      cap_data.push_back(oRamData1);
    end
    if (oRamEnable2) begin
      cap_addr.push_back(oRamAddress2);
      cap_data.push_back(oRamData2);
      if (!oRamEnable1) p2_alone++;
    end
    if (oFrameDone) begin
      if (fd_cnt < 8) done_idx[fd_cnt] = cap_data.size();
      fd_cnt++;
    end
  end

  function automatic logic [15:0] cap_at(input int i);
    if (i < cap_data.size()) return cap_data[i];
    return 16'hDEAD;
  endfunction

  // Frame D: one -32768 (u=65535, k=12, q=15) then 4095 zeros ("1"+12 zeros).
  // Header 0000001100, code 15 zeros, 1, twelve ones; 53273 bits in total.
  function automatic logic exp_bit_d(input int i);
    if (i < 10)     return (i == 6 || i == 7);
    if (i < 25)     return 1'b0;
    if (i < 38)     return 1'b1;
    if (i >= 53273) return 1'b0;
    return ((i - 38) % 13) == 0;
  endfunction

  task automatic send_frame(input int kind);
    for (int i = 0; i < 4096; i++) begin
      @(negedge iClock);
      iValid = 1'b1;
      case (kind)
        0:       iResidual = 16'h0000;
        1:       iResidual = 16'h0001;
        2:       iResidual = 16'hFFFF;
        default: iResidual = (i == 0) ? 16'h8000 : 16'h0000;
      endcase
    end
    @(negedge iClock);
    iValid = 1'b0;
  endtask

  task automatic pulse();
    repeat (12) @(negedge iClock);
    iFrameDone = 1'b1;
    @(negedge iClock);
    iFrameDone = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int c;
    c = 0;
    while (fd_cnt < target && c < limit) begin
      @(negedge iClock);
      c++;
    end
    check_eq(tag, fd_cnt, target);
  endtask

  initial begin
    int bad, c, d_end, snap, stall_strobes;
    logic [15:0] hold_addr, hold_data, e;

    iReset = 1'b0; iEnable = 1'b1; iFrameDone = 1'b0; iValid = 1'b0;
    iM = 4'd0; iResidual = '0;
    repeat (3) @(negedge iClock);
    check_eq("rst_en1",   oRamEnable1,  0);
    check_eq("rst_addr1", oRamAddress1, 0);
    check_eq("rst_data1", oRamData1,    0);
    check_eq("rst_en2",   oRamEnable2,  0);
    check_eq("rst_data2", oRamData2,    0);
    check_eq("rst_fdone", oFrameDone,   0);
    iReset = 1'b1;
    @(negedge iClock);

    pulse();                 // closes the empty frame before A
    send_frame(0);           // A: zeros
    check_eq("first_pulse_no_writes", cap_data.size(), 0);
    check_eq("first_pulse_no_done",   fd_cnt, 0);
    pulse();
    send_frame(1);           // B: +1
    pulse();
    send_frame(2);           // C: -1
    pulse();
    send_frame(3);           // D
    pulse();

    // Freeze for 10 cycles while D is being encoded.
    repeat (200) @(negedge iClock);
    iEnable = 1'b0;
    hold_addr = oRamAddress1;
    hold_data = oRamData1;
    stall_strobes = 0;
    repeat (10) begin
      @(posedge iClock);
      #1;
      if (oRamEnable1 || oRamEnable2 || oFrameDone) stall_strobes++;
    end
    check_eq("stall_no_strobes", stall_strobes, 0);
    check_eq("stall_addr_frozen", oRamAddress1, hold_addr);
    check_eq("stall_data_frozen", oRamData1, hold_data);
    @(negedge iClock);
    iEnable = 1'b1;

    wait_done(4, 5000, "done_d");
    d_end = cap_data.size();

    // Frame E (100 x +1), then reset while it is being written out.
    for (int i = 0; i < 100; i++) begin
      @(negedge iClock);
      iValid = 1'b1;
      iResidual = 16'h0001;
    end
    @(negedge iClock);
    iValid = 1'b0;
    pulse();
    c = 0;
    while (!oRamEnable1 && c < 60) begin
      @(negedge iClock);
      c++;
    end
    check_eq("e_write_seen", oRamEnable1, 1);
    iReset = 1'b0;
    #1;
    check_eq("midrst_en1",   oRamEnable1,  0);
    check_eq("midrst_addr1", oRamAddress1, 0);
    check_eq("midrst_data1", oRamData1,    0);
    check_eq("midrst_en2",   oRamEnable2,  0);
    check_eq("midrst_fdone", oFrameDone,   0);
    repeat (2) @(negedge iClock);
    iReset = 1'b1;
    snap = cap_data.size();
    pulse();
    repeat (30) @(negedge iClock);
    check_eq("after_rst_no_writes", cap_data.size(), snap);
    check_eq("after_rst_no_done",   fd_cnt, 4);

    // Frame boundaries: A 257 words, B 769, C 513, D 3330.
    check_eq("end_a", done_idx[0], 257);
    check_eq("end_b", done_idx[1], 1026);
    check_eq("end_c", done_idx[2], 1539);
    check_eq("end_d", done_idx[3], 4869);
    check_eq("words_total", d_end, 4869);

    check_eq("a_w0", cap_at(0), 16'h003F);
    bad = 0;
    for (int w = 1; w < 256; w++) if (cap_at(w) !== 16'hFFFF) bad++;
    check_eq("a_mid_words", bad, 0);
    check_eq("a_w256", cap_at(256), 16'hFFC0);

    check_eq("b_addr0", (257 < cap_addr.size()) ? cap_addr[257] : 16'hDEAD, 16'd257);
    check_eq("b_w0",   cap_at(257),  16'h0052);
    check_eq("b_w1",   cap_at(258),  16'h4924);
    check_eq("b_last", cap_at(1025), 16'h2480);

    check_eq("c_w0",   cap_at(1026), 16'h0015);
    check_eq("c_w1",   cap_at(1027), 16'h5555);
    check_eq("c_last", cap_at(1538), 16'h5540);

    check_eq("d_w0",   cap_at(1539), 16'h0300);
    check_eq("d_w1",   cap_at(1540), 16'h007F);
    check_eq("d_w2",   cap_at(1541), 16'hFE00);
    check_eq("d_last", cap_at(4868), 16'h0000);
    bad = 0;
    for (int w = 0; w < 3330; w++) begin
      e = '0;
      for (int b = 0; b < 16; b++) e[15-b] = exp_bit_d(w * 16 + b);
      if (cap_at(1539 + w) !== e) bad++;
    end
    check_eq("d_stream", bad, 0);

    bad = 0;
    for (int i = 0; i < d_end; i++) if (cap_addr[i] !== 16'(i)) bad++;
    check_eq("addr_sequential", bad, 0);
    check_eq("port2_without_port1", p2_alone, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
